up_counter_ctl_311: RTL
=======================

// Module: up_counter_ctl_311
// PURPOSE
//  Loadable, enable-gated modulo up counter with a run/stop/one-shot controller.
//  Counting complement to the 8-bit down counter in the counters library.
//  Used as an event/interval counter and timeout generator.
//  Wrap and done flags let it be cascaded or used to trigger downstream logic.
// PARAMETERS
//  WIDTH  8    counter width in bits
//  MAXV   255  terminal value; count sequence is 0..MAXV; requires MAXV <= 2**WIDTH-1
// PORTS
//  clk_311       in   1      clock; all state updates on negedge clk_311
//  reset_n_311   in   1      asynchronous active-low reset
//  start_311     in   1      begin counting (IDLE/DONE -> RUN)
//  stop_311      in   1      halt counting (RUN -> IDLE), count held
//  oneshot_311   in   1      1: stop at MAXV; 0: free-run with wrap
//  en_311        in   1      count enable, qualifies increments in RUN
//  clear_311     in   1      synchronous clear of count to 0
//  load_311      in   1      synchronous load of load_val_311
//  load_val_311  in   WIDTH  value to load
//  count_311     out  WIDTH  current count (registered)
//  tc_311        out  1      terminal count, combinational: count_311==MAXV
//  wrap_311      out  1      one-cycle pulse, registered: count went MAXV->0
//  busy_311      out  1      1 while state==RUN
//  done_311      out  1      1 while state==DONE
// BEHAVIOUR
//  Reset (reset_n_311=0, async, any time incl. mid-count):
//   count_311=0, state=IDLE, wrap_311=0, busy_311=0, done_311=0; tc_311=(MAXV==0).
//  FSM states: IDLE, RUN, DONE. Transitions are evaluated each negedge.
//  Transitions:
//   IDLE -> RUN on start_311.
//   RUN -> IDLE on stop_311.
//   RUN -> DONE when oneshot_311=1, en_311=1 and count_311==MAXV.
//   DONE -> RUN on start_311; otherwise DONE holds.
//   stop_311 has priority over start_311 when both are asserted.
//   stop_311 in DONE returns to IDLE.
//  Count update priority per edge: clear_311 > load_311 > increment.
//   clear/load act in any state and do not change state.
//   load: count_311 <= min(load_val_311, MAXV); values > MAXV saturate to MAXV.
//   increment: only in RUN with en_311=1.
//   free-run (oneshot_311=0): at MAXV, count <= 0 and wrap_311=1 next cycle; else count+1.
//   one-shot: at MAXV the count holds at MAXV, state -> DONE, no wrap pulse.
//  Start from DONE: count <= 0 on the same edge as DONE -> RUN, unless clear/load also asserted.
//  Latency: count_311 and the flags change one edge after their inputs are sampled.
//  wrap_311 is 0 on every cycle except the one after a wrap.
//  Arithmetic is unsigned WIDTH-bit; count never exceeds MAXV.
//  oneshot_311 may change at any time; it takes effect on the next compare at MAXV.
// TESTING  (WIDTH=8, MAXV=255 unless noted)
//  1. Assert reset mid-count at 0x37 -> count=0, state=IDLE, all flags 0 immediately (async).
//  2. start, en=1, oneshot=0, run 260 edges:
//     count 0..255, then 0; wrap=1 for exactly one cycle; count=4 at the end.
//  3. MAXV=9, oneshot=1, start:
//     count reaches 9 and holds; done=1, busy=0, tc=1; another start restarts from 0.
//  4. In RUN at 0x10, toggle en low for 5 cycles -> count holds at 0x10, then resumes to 0x11.
//  5. Assert clear and load (load_val=0x80) on the same edge -> count=0.
//     MAXV=100 with load_val=200 -> count=100, tc=1.
//  6. Assert start and stop together in IDLE -> stays IDLE.
//     stop in RUN at 0x42 -> IDLE with count=0x42 held.

Source files
------------

// File: rtl/up_counter_ctl_311.sv
// Loadable, enable-gated modulo up counter (0..MAXV) with a run/stop/one-shot controller.
// All state updates happen on the falling edge of clk_311; reset is asynchronous active-low.
module up_counter_ctl_311 #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned MAXV  = 255
) (
  input  logic             clk_311,
  input  logic             reset_n_311,
  input  logic             start_311,
  input  logic             stop_311,
  input  logic             oneshot_311,
  input  logic             en_311,
  input  logic             clear_311,
  input  logic             load_311,
  input  logic [WIDTH-1:0] load_val_311,
  output logic [WIDTH-1:0] count_311,
  output logic             tc_311,
  output logic             wrap_311,
  output logic             busy_311,
  output logic             done_311
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAXV);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] count_nxt;
  logic             wrap_nxt;
  logic             at_max;
  logic             inc;

  assign at_max   = (count_311 == MAX_C);
  // A stop on this edge freezes the count as well as the state.
  assign inc      = (state == RUN) && en_311 && !stop_311;
  assign tc_311   = at_max;
  assign busy_311 = (state == RUN);
  assign done_311 = (state == DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start_311 && !stop_311) state_nxt = RUN;
      RUN: begin
        if (stop_311)                                state_nxt = IDLE;
        else if (oneshot_311 && en_311 && at_max)    state_nxt = DONE;
      end
      DONE: begin
        if (stop_311)       state_nxt = IDLE;
        else if (start_311) state_nxt = RUN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    count_nxt = count_311;
    wrap_nxt  = 1'b0;
    if (clear_311) begin
      count_nxt = '0;
    end else if (load_311) begin
      count_nxt = (load_val_311 > MAX_C) ? MAX_C : load_val_311;
    end else if (inc) begin
      if (!at_max) begin
        count_nxt = count_311 + 1'b1;
      end else if (!oneshot_311) begin
        count_nxt = '0;
        wrap_nxt  = 1'b1;
      end
    end else if ((state == DONE) && start_311 && !stop_311) begin
      count_nxt = '0;
    end
  end

  always_ff @(negedge clk_311 or negedge reset_n_311) begin
    if (!reset_n_311) begin
      state     <= IDLE;
      count_311 <= '0;
      wrap_311  <= 1'b0;
    end else begin
      state     <= state_nxt;
      count_311 <= count_nxt;
      wrap_311  <= wrap_nxt;
    end
  end

endmodule
